// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared CPU definitions for the instruction-fetch front end.
//   - fetch_state_t : two-state fetch FSM encoding (FETCH / ISSUE)
//   - DEF_RESET_PC  : default first fetch address after reset
//   - DEF_EXC_VEC   : default exception handler address
//   - instruction field bit positions (opcode, funct, jump target, immediate)
//   - helpers for branch offset and jump target formation
package pc_fetch_pkg;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,   // request outstanding on the instruction bus
        ST_ISSUE = 1'b1    // instruction held for decode
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h8000_0180;
    localparam logic [31:0] PC_STEP      = 32'd4;

    // Instruction field positions as seen by the decoder and the next-PC mux
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Sign-extend a 16-bit branch immediate and scale it to a byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump: region bits come from the sequential PC
    function automatic logic [31:0] jump_target(input logic [31:0] seq_pc,
                                                input logic [25:0] tgt);
        return {seq_pc[31:28], tgt, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_npc_sel.sv
// npc_sel: combinational next-PC selection.
//   Ports:
//     pc        in  32  address of the current instruction
//     instr_idx in  26  low 26 bits of the current instruction (target / imm)
//     excp      in  1   illegal instruction, highest priority
//     jr        in  1   register jump
//     jr_addr   in  32  register jump target (low two bits dropped)
//     jump      in  1   pseudo-direct jump
//     br_taken  in  1   resolved-taken conditional branch
//     npc       out 32  selected next PC
//     pc_plus4  out 32  sequential PC (pc + 4, wraps modulo 2^32)
module npc_sel
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic        excp,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        jump,
    input  logic        br_taken,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic [31:0] seq_pc_s;

    // Priority mux: exception beats every redirect, then jr, jump, branch
    always_comb begin
        seq_pc_s = pc + PC_STEP;
        npc      = seq_pc_s;
        if (excp) begin
            npc = EXC_VEC;
        end else if (jr) begin
            npc = jr_addr & 32'hFFFF_FFFC;
        end else if (jump) begin
            npc = jump_target(seq_pc_s, instr_idx[TARGET_MSB:TARGET_LSB]);
        end else if (br_taken) begin
            npc = seq_pc_s + branch_offset(instr_idx[IMM_MSB:IMM_LSB]);
        end else begin
            npc = seq_pc_s;
        end
    end

    assign pc_plus4 = seq_pc_s;

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch unit with a two-state FETCH/ISSUE FSM.
//   Parameters: RESET_PC (first fetch address), EXC_VEC (exception vector).
//   Ports:
//     clk, reset          clock and synchronous active-high reset
//     imem_req/imem_addr  instruction read request and word address
//     imem_ready/rdata    read completion and returned word
//     instr/instr_valid   held instruction, valid while in ISSUE
//     stall               downstream hold, blocks retirement
//     excp, br_taken, jump, jr, jr_addr   redirect controls for the held instr
//     pc, pc_plus4, epc   current PC, its link value, last faulting PC
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        excp,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc
);

    fetch_state_t state_r;
    logic [31:0]  pc_r;
    logic [31:0]  instr_r;
    logic [31:0]  epc_r;
    logic [31:0]  npc_s;
    logic [31:0]  pc_plus4_s;

    npc_sel #(
        .EXC_VEC (EXC_VEC)
    ) u_npc_sel (
        .pc        (pc_r),
        .instr_idx (instr_r[TARGET_MSB:TARGET_LSB]),
        .excp      (excp),
        .jr        (jr),
        .jr_addr   (jr_addr),
        .jump      (jump),
        .br_taken  (br_taken),
        .npc       (npc_s),
        .pc_plus4  (pc_plus4_s)
    );

    // Fetch FSM with PC, instruction and EPC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            epc_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ready) begin
                        instr_r <= imem_rdata;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Redirect inputs only matter here, on the retiring cycle
                    if (!stall) begin
                        pc_r    <= npc_s;
                        state_r <= ST_FETCH;
                        if (excp) begin
                            epc_r <= pc_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    // The request is gated by reset directly so the bus sees no request
    // during the reset cycle itself, before the state register is cleared.
    assign imem_req    = (state_r == ST_FETCH) && !reset;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = (state_r == ST_ISSUE);
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign epc         = epc_r;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed stimulus with a scoreboard. Stimulus pushes expected
// fetch addresses and retiring instructions into queues; a monitor pops and
// compares whenever the DUT completes a fetch or retires an instruction.
module tb_pc_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        excp;
    logic        br_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } retire_t;

    logic [31:0] fetch_q[$];
    retire_t     retire_q[$];
    int          checks;
    int          errors;
    logic [31:0] mon_addr;
    retire_t     mon_ret;

    pc_fetch #(
        .RESET_PC (32'h0040_0000),
        .EXC_VEC  (32'h8000_0180)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .excp        (excp),
        .br_taken    (br_taken),
        .jump        (jump),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .epc         (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare completed fetches and retiring instructions
    always @(negedge clk) begin
        if (!reset && imem_req && imem_ready) begin
            if (fetch_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fetch_unexpected: got addr %h expected none", imem_addr);
            end else begin
                mon_addr = fetch_q.pop_front();
                check32("fetch_addr", imem_addr, mon_addr);
            end
        end
        if (!reset && instr_valid && !stall) begin
            if (retire_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got pc %h expected none", pc);
            end else begin
                mon_ret = retire_q.pop_front();
                check32("retire_pc", pc, mon_ret.pc);
                check32("retire_instr", instr, mon_ret.instr);
                check32("retire_pc_plus4", pc_plus4, mon_ret.pc4);
            end
        end
    end

    // Complete one fetch after 'waits' not-ready cycles; 'noise' drives
    // redirect inputs during the wait, which must have no effect.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                            input int waits, input logic noise);
        fetch_q.push_back(exp_addr);
        imem_ready = 1'b0;
        excp = noise; jr = noise; jump = noise; br_taken = noise;
        jr_addr = noise ? 32'hDEAD_BEE0 : 32'h0000_0000;
        for (int i = 0; i < waits; i++) begin
            step();
            check1("wait_req", imem_req, 1'b1);
            check32("wait_addr", imem_addr, exp_addr);
        end
        imem_rdata = rdata;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        excp = 1'b0; jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
        jr_addr = 32'h0000_0000;
        check1("issue_valid", instr_valid, 1'b1);
        check1("issue_req", imem_req, 1'b0);
    endtask

    // Hold the instruction for 'stalls' cycles, then retire it with the
    // given redirect inputs.
    task automatic do_issue(input logic [31:0] exp_pc, input logic [31:0] exp_instr,
                            input logic [31:0] exp_pc4, input logic e, input logic j_r,
                            input logic [31:0] j_addr, input logic j, input logic b,
                            input int stalls, input logic [31:0] exp_epc);
        retire_t r;
        r.pc = exp_pc; r.instr = exp_instr; r.pc4 = exp_pc4;
        retire_q.push_back(r);
        excp = e; jr = j_r; jr_addr = j_addr; jump = j; br_taken = b;
        stall = (stalls > 0);
        for (int i = 0; i < stalls; i++) begin
            step();
            check32("stall_pc", pc, exp_pc);
            check32("stall_instr", instr, exp_instr);
            check1("stall_valid", instr_valid, 1'b1);
        end
        stall = 1'b0;
        step();
        excp = 1'b0; jr = 1'b0; jr_addr = 32'h0000_0000; jump = 1'b0; br_taken = 1'b0;
        check1("retired_valid", instr_valid, 1'b0);
        check32("epc", epc, exp_epc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0000_0000;
        stall = 1'b0;
        excp = 1'b0; br_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        jr_addr = 32'h0000_0000;
        step();
        step();
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", instr_valid, 1'b0);
        check32("rst_pc", pc, 32'h0040_0000);
        check32("rst_instr", instr, 32'h0000_0000);
        check32("rst_epc", epc, 32'h0000_0000);
        reset = 1'b0;
        #1;
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0040_0000);

        // Sequential
        do_fetch(32'h0040_0000, 32'h2008_0005, 0, 1'b0);
        do_issue(32'h0040_0000, 32'h2008_0005, 32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        // jr with misaligned target, redirect noise while fetching
        do_fetch(32'h0040_0004, 32'h0000_0020, 2, 1'b1);
        do_issue(32'h0040_0004, 32'h0000_0020, 32'h0040_0008, 1'b0, 1'b1, 32'h0040_0013, 1'b0, 1'b0, 0, 32'h0);
        // Backward branch with a 3-cycle stall
        do_fetch(32'h0040_0010, 32'h1000_FFFC, 0, 1'b0);
        do_issue(32'h0040_0010, 32'h1000_FFFC, 32'h0040_0014, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3, 32'h0);
        // jr beats jump
        do_fetch(32'h0040_0004, 32'h0000_0000, 0, 1'b0);
        do_issue(32'h0040_0004, 32'h0000_0000, 32'h0040_0008, 1'b0, 1'b1, 32'h0040_0020, 1'b1, 1'b0, 0, 32'h0);
        // jump beats branch
        do_fetch(32'h0040_0020, 32'h0810_0000, 1, 1'b0);
        do_issue(32'h0040_0020, 32'h0810_0000, 32'h0040_0024, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0, 32'h0);
        do_fetch(32'h0040_0000, 32'h0000_0000, 0, 1'b0);
        do_issue(32'h0040_0000, 32'h0000_0000, 32'h0040_0004, 1'b0, 1'b1, 32'h0040_0008, 1'b0, 1'b0, 0, 32'h0);
        // Exception beats all redirects, epc captured
        do_fetch(32'h0040_0008, 32'hFFFF_FFFF, 0, 1'b0);
        do_issue(32'h0040_0008, 32'hFFFF_FFFF, 32'h0040_000C, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 1, 32'h0040_0008);
        // epc holds on a non-exception retire
        do_fetch(32'h8000_0180, 32'h0000_0000, 0, 1'b0);
        do_issue(32'h8000_0180, 32'h0000_0000, 32'h8000_0184, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 0, 32'h0040_0008);
        // Wrap-around
        do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 0, 1'b0);
        do_issue(32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0040_0008);
        // Forward branch from 0
        do_fetch(32'h0000_0000, 32'h1000_0001, 1, 1'b1);
        do_issue(32'h0000_0000, 32'h1000_0001, 32'h0000_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0, 32'h0040_0008);

        // Fetch at 0x8 never completes; reset lands on its third cycle
        imem_ready = 1'b0;
        step();
        check1("hang_req", imem_req, 1'b1);
        check32("hang_addr", imem_addr, 32'h0000_0008);
        step();
        reset = 1'b1;
        imem_ready = 1'b1;
        stall = 1'b1;
        #1;
        check1("mid_rst_req", imem_req, 1'b0);
        step();
        check1("mid_rst_req2", imem_req, 1'b0);
        check32("mid_rst_pc", pc, 32'h0040_0000);
        check32("mid_rst_instr", instr, 32'h0000_0000);
        check32("mid_rst_epc", epc, 32'h0000_0000);
        check1("mid_rst_valid", instr_valid, 1'b0);
        reset = 1'b0;
        imem_ready = 1'b0;
        stall = 1'b0;
        step();
        check1("restart_req", imem_req, 1'b1);
        check32("restart_addr", imem_addr, 32'h0040_0000);
        do_fetch(32'h0040_0000, 32'h2008_0005, 0, 1'b0);
        do_issue(32'h0040_0000, 32'h2008_0005, 32'h0040_0004, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
        do_fetch(32'h0040_0004, 32'h0000_0000, 0, 1'b0);
        stall = 1'b1;
        step();
        step();

        checks++;
        if (fetch_q.size() != 0 || retire_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d fetch and %0d retire pending, expected 0",
                     fetch_q.size(), retire_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0040_0000, first fetch address after reset.
REQ-002 Parameter: EXC_VEC, default 32'h8000_0180, exception handler address.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  reset, synchronous, active-high.
REQ-005 Port: imem_req  out  1  instruction-memory read request.
REQ-006 Port: imem_addr  out  32  word-aligned fetch address.
REQ-007 Port: imem_ready  in  1  imem_rdata valid this cycle, completes the request.
REQ-008 Port: imem_rdata  in  32  fetched instruction word.
REQ-009 Port: instr  out  32  held instruction; decoder consumes [31:26] as opCode, [5:0] as funct.
REQ-010 Port: instr_valid  out  1  instr is valid, in ISSUE state.
REQ-011 Port: stall  in  1  downstream hold; instr must not retire.
REQ-012 Port: excp  in  1  illegal-instruction flag from decoder for current instr.
REQ-013 Port: br_taken  in  1  conditional branch resolved taken.
REQ-014 Port: jump  in  1  j/jal of current instr.
REQ-015 Port: jr  in  1  jr of current instr.
REQ-016 Port: jr_addr  in  32  register-sourced jump target.
REQ-017 Port: pc  out  32  address of current instr.
REQ-018 Port: pc_plus4  out  32  pc + 4, jal link value.
REQ-019 Port: epc  out  32  address of last faulting instruction.

Function
REQ-020 The FSM SHALL have states FETCH (request outstanding) and ISSUE (instr held for decode).
REQ-021 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; in ISSUE, imem_req SHALL be 0.
REQ-022 In FETCH with imem_ready=1, instr SHALL capture imem_rdata and the state SHALL become ISSUE next cycle; without imem_ready, state and pc SHALL hold.
REQ-023 instr_valid SHALL be 1 exactly when state is ISSUE.
REQ-024 An instruction SHALL retire in ISSUE only when stall=0; with stall=1, pc, instr and state SHALL hold.
REQ-025 On retire, next pc SHALL be selected by priority: excp -> EXC_VEC; jr -> jr_addr; jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; br_taken -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-026 On a retire with excp=1, epc SHALL load the current pc; epc SHALL otherwise hold.
REQ-027 Each retire SHALL return the state to FETCH; minimum fetch-to-next-fetch spacing is 2 cycles (FETCH with ready, ISSUE).
REQ-028 jr_addr[1:0] SHALL be forced to 0 when loaded into pc.
REQ-029 All adds SHALL be 32-bit modulo; pc 32'hFFFF_FFFC + 4 wraps to 0.
REQ-030 Redirect inputs SHALL be ignored outside ISSUE.
REQ-031 Simultaneous excp and any redirect SHALL take EXC_VEC only.

Reset
REQ-032 On reset: pc = RESET_PC, state = FETCH, instr = 0, epc = 0, instr_valid = 0.
REQ-033 Reset SHALL override stall and imem_ready in the same cycle; a fetch in progress is abandoned and reissued at RESET_PC.
REQ-034 With reset=1, imem_req SHALL be 0.

Structure
REQ-035 FSM state enum, RESET_PC and EXC_VEC defaults, and opcode field bit positions SHALL live in a shared CPU package.
REQ-036 A sub-module npc_sel (combinational next-PC mux, REQ-025/028/029) SHALL be instantiated; the FSM and registers remain in pc_fetch.

Verification
REQ-037 Reset, imem_ready=1, rdata=32'h2008_0005 -> first imem_addr 0x0040_0000; instr_valid=1 on cycle 2; next imem_addr 0x0040_0004.
REQ-038 ISSUE at pc 0x0040_0010, instr offset 16'hFFFC, br_taken=1 -> next imem_addr 0x0040_0004.
REQ-039 ISSUE at pc 0x0040_0020, jump=1, instr[25:0]=26'h010_0000 -> next imem_addr 0x0040_0000.
REQ-040 ISSUE at pc 0x0040_0008, excp=1 and jr=1, jr_addr 0x1234 -> pc 0x8000_0180, epc 0x0040_0008.
REQ-041 stall=1 for 3 cycles in ISSUE -> pc, instr, instr_valid unchanged; retire on first cycle with stall=0.
REQ-042 imem_ready held 0 for 4 cycles, reset asserted on cycle 3 -> imem_req 0 during reset, fetch restarts at 0x0040_0000.
